// File: rtl/dct_pkg.sv
// Shared constants, FSM state type and cosine basis table for the 8x8 forward DCT sequencer.
// The basis is kept in Q14 so products of two basis values can be rounded to the 8-bit fraction.
package dct_pkg;

  localparam int N               = 8;
  localparam int COS_FRAC_BITS   = 8;
  localparam int ACC_W           = 32;
  localparam int BASIS_FRAC_BITS = 14;
  localparam int PIX_LEVEL_SHIFT = 128;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUT,
    FIN
  } state_e;

  // cos((2n+1)*k*pi/16) in Q14; the angle index is folded into the first quadrant by symmetry.
  function automatic logic signed [15:0] cos_basis(input logic [2:0] k, input logic [2:0] n);
    logic [4:0]         r;
    logic [3:0]         idx;
    logic               neg;
    logic signed [15:0] mag;
    r = 5'({1'b0, n, 1'b1} * {2'b00, k});
    if (r > 5'd16) begin
      r = 5'd0 - r;
    end
    neg = (r > 5'd8);
    idx = neg ? 4'(5'd16 - r) : r[3:0];
    case (idx)
      4'd0:    mag = 16'sd16384;
      4'd1:    mag = 16'sd16069;
      4'd2:    mag = 16'sd15137;
      4'd3:    mag = 16'sd13623;
      4'd4:    mag = 16'sd11585;
      4'd5:    mag = 16'sd9102;
      4'd6:    mag = 16'sd6270;
      4'd7:    mag = 16'sd3196;
      default: mag = 16'sd0;
    endcase
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// Combinational cosine term for (k1,k2,n1,n2): product of row and column basis values,
// rounded (half up) to COS_FRAC_BITS fractional bits.
module dct_cos_rom
  import dct_pkg::*;
(
  input  logic [2:0]              k1_i,
  input  logic [2:0]              k2_i,
  input  logic [2:0]              n1_i,
  input  logic [2:0]              n2_i,
  output logic signed [ACC_W-1:0] cos_term_o
);

  localparam int BASIS_SHIFT = 2 * BASIS_FRAC_BITS - COS_FRAC_BITS;
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) <<< (BASIS_SHIFT - 1);

  logic signed [15:0]      row_c;
  logic signed [15:0]      col_c;
  logic signed [ACC_W-1:0] row_ext;
  logic signed [ACC_W-1:0] col_ext;
  logic signed [ACC_W-1:0] prod;

  always_comb begin
    row_c      = cos_basis(k1_i, n1_i);
    col_c      = cos_basis(k2_i, n2_i);
    row_ext    = {{(ACC_W-16){row_c[15]}}, row_c};
    col_ext    = {{(ACC_W-16){col_c[15]}}, col_c};
    prod       = row_ext * col_ext;
    cos_term_o = (prod + ROUND_HALF) >>> BASIS_SHIFT;
  end

endmodule

// File: rtl/dct_mac_sequencer.sv
// Sequences an 8x8 forward DCT one coefficient at a time: 64 pixel reads per (k1,k2),
// multiply-accumulate against the cosine term, then a valid/ready hand-off of the result.
module dct_mac_sequencer
  import dct_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic [5:0]              pix_addr,
  output logic                    pix_rd,
  input  logic [7:0]              pix_data,
  output logic signed [ACC_W-1:0] coeff,
  output logic [2:0]              coeff_k1,
  output logic [2:0]              coeff_k2,
  output logic                    coeff_valid,
  input  logic                    coeff_ready,
  output logic                    done
);

  localparam logic signed [8:0] PIX_OFFSET = 9'(PIX_LEVEL_SHIFT);
  localparam logic [5:0]        LAST_ADDR  = 6'(N * N - 1);
  localparam logic [2:0]        LAST_K     = 3'(N - 1);

  state_e                  state_q;
  logic [2:0]              k1_q;
  logic [2:0]              k2_q;
  logic [5:0]              pix_addr_q;
  logic                    pix_rd_q;
  logic [5:0]              samp_addr_q;
  logic                    samp_vld_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] coeff_q;
  logic [2:0]              coeff_k1_q;
  logic [2:0]              coeff_k2_q;
  logic                    coeff_valid_q;
  logic                    done_q;

  logic signed [ACC_W-1:0] cos_term;
  logic signed [8:0]       pix_shift;
  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] product;

  // The address travels one cycle behind the read strobe so it lines up with the returned pixel.
  dct_cos_rom u_cos_rom (
    .k1_i       (k1_q),
    .k2_i       (k2_q),
    .n1_i       (samp_addr_q[5:3]),
    .n2_i       (samp_addr_q[2:0]),
    .cos_term_o (cos_term)
  );

  always_comb begin
    pix_shift = $signed({1'b0, pix_data}) - PIX_OFFSET;
    pix_ext   = {{(ACC_W-9){pix_shift[8]}}, pix_shift};
    product   = pix_ext * cos_term;
    acc_d     = acc_q;
    if (samp_vld_q) begin
      acc_d = acc_q + product;
    end
  end

  // OUT spends its first cycle latching the finished accumulator, so the result is held stable
  // from the moment coeff_valid rises until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      k1_q          <= '0;
      k2_q          <= '0;
      pix_addr_q    <= '0;
      pix_rd_q      <= 1'b0;
      samp_addr_q   <= '0;
      samp_vld_q    <= 1'b0;
      acc_q         <= '0;
      coeff_q       <= '0;
      coeff_k1_q    <= '0;
      coeff_k2_q    <= '0;
      coeff_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      samp_vld_q  <= pix_rd_q;
      samp_addr_q <= pix_addr_q;
      acc_q       <= acc_d;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FETCH;
            k1_q       <= '0;
            k2_q       <= '0;
            acc_q      <= '0;
            pix_addr_q <= '0;
            pix_rd_q   <= 1'b1;
          end
        end
        FETCH: begin
          if (pix_addr_q == LAST_ADDR) begin
            state_q  <= DRAIN;
            pix_rd_q <= 1'b0;
          end else begin
            pix_addr_q <= pix_addr_q + 6'd1;
          end
        end
        DRAIN: begin
          state_q <= OUT;
        end
        OUT: begin
          if (!coeff_valid_q) begin
            coeff_q       <= acc_q >>> COS_FRAC_BITS;
            coeff_k1_q    <= k1_q;
            coeff_k2_q    <= k2_q;
            coeff_valid_q <= 1'b1;
          end else if (coeff_ready) begin
            coeff_valid_q <= 1'b0;
            if ((k1_q == LAST_K) && (k2_q == LAST_K)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              k2_q <= k2_q + 3'd1;
              if (k2_q == LAST_K) begin
                k1_q <= k1_q + 3'd1;
              end
              acc_q      <= '0;
              state_q    <= FETCH;
              pix_addr_q <= '0;
              pix_rd_q   <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign pix_addr    = pix_addr_q;
  assign pix_rd      = pix_rd_q;
  assign coeff       = coeff_q;
  assign coeff_k1    = coeff_k1_q;
  assign coeff_k2    = coeff_k2_q;
  assign coeff_valid = coeff_valid_q;
  assign done        = done_q;

endmodule
